imuldiv_three_mul_client: RTL and testbench



---
 rtl/imuldiv_three_mul_client_pkg.sv | 43 ++++
 rtl/imuldiv_resp_serializer.sv | 59 +++++
 rtl/imuldiv_three_mul_client.sv | 199 +++++++++++++++++++
 tb/tb_imuldiv_three_mul_client.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_three_mul_client_pkg.sv
// Shared types and constants for the three-operand multiply client.
// State encoding, beat indices, function code and slice helpers.
package imuldiv_three_mul_client_pkg;

  localparam int WORD_W   = 32;
  localparam int RESULT_W = 96;

  localparam logic [2:0] FN_MUL = 3'd0;

  localparam logic [1:0] BEAT_0 = 2'd0;
  localparam logic [1:0] BEAT_1 = 2'd1;
  localparam logic [1:0] BEAT_2 = 2'd2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } client_state_e;

  function automatic logic [WORD_W-1:0] result_slice(input logic [RESULT_W-1:0] r,
                                                     input logic [1:0]          idx);
    logic [WORD_W-1:0] s;
    case (idx)
      BEAT_0:  s = r[31:0];
      BEAT_1:  s = r[63:32];
      BEAT_2:  s = r[95:64];
      default: s = {WORD_W{1'b0}};
    endcase
    return s;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] n;
    if (v == 16'hFFFF) begin
      n = v;
    end else begin
      n = v + 16'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/imuldiv_resp_serializer.sv
// Holds a latched 96-bit product and streams it out as three 32-bit
// val/rdy beats, low word first.
module imuldiv_resp_serializer
  import imuldiv_three_mul_client_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [RESULT_W-1:0] result,
  output logic [WORD_W-1:0]   out_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                done
);

  logic [RESULT_W-1:0] result_r;
  logic [1:0]          beat_r;
  logic [WORD_W-1:0]   out_msg_r;
  logic                out_val_r;
  logic                fire_s;
  logic                last_s;
  logic [1:0]          beat_nxt_s;

  // Handshake decode and next beat index
  always_comb begin
    fire_s     = out_val_r && out_rdy;
    last_s     = (beat_r == BEAT_2);
    beat_nxt_s = beat_r;
    if (last_s) begin
      beat_nxt_s = BEAT_0;
    end else begin
      beat_nxt_s = beat_r + 2'd1;
    end
  end

  // Result latch, beat counter and registered output word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r  <= {RESULT_W{1'b0}};
      beat_r    <= BEAT_0;
      out_msg_r <= {WORD_W{1'b0}};
      out_val_r <= 1'b0;
    end else if (load) begin
      result_r  <= result;
      beat_r    <= BEAT_0;
      out_msg_r <= result_slice(result, BEAT_0);
      out_val_r <= 1'b1;
    end else if (fire_s) begin
      beat_r    <= beat_nxt_s;
      out_msg_r <= result_slice(result_r, beat_nxt_s);
      out_val_r <= !last_s;
    end
  end

  assign out_msg = out_msg_r;
  assign out_val = out_val_r;
  assign done    = fire_s && last_s;

endmodule

// File: rtl/imuldiv_three_mul_client.sv
// Word-serial client for the three-input multiplier: collects A/B/C, issues
// one request, returns the 96-bit product as three beats. Optional perf
// counters are enabled by defining IMULDIV_CLIENT_PERF_EN.
module imuldiv_three_mul_client
  import imuldiv_three_mul_client_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  FN_CODE        = FN_MUL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   in_msg,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [2:0]          muldivreq_msg_fn,
  output logic [WORD_W-1:0]   muldivreq_msg_a,
  output logic [WORD_W-1:0]   muldivreq_msg_b,
  output logic [WORD_W-1:0]   muldivreq_msg_c,
  output logic                muldivreq_val,
  input  logic                muldivreq_rdy,
  input  logic [RESULT_W-1:0] muldivresp_msg_result,
  input  logic                muldivresp_val,
  output logic                muldivresp_rdy,
  output logic [WORD_W-1:0]   out_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                err_timeout
`ifdef IMULDIV_CLIENT_PERF_EN
  ,
  output logic [31:0]         perf_txn_count,
  output logic [15:0]         perf_last_latency
`endif
);

  localparam logic        TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  client_state_e     state_r;
  client_state_e     state_nxt_s;
  logic [1:0]        beat_r;
  logic [WORD_W-1:0] a_r;
  logic [WORD_W-1:0] b_r;
  logic [WORD_W-1:0] c_r;
  logic [15:0]       wait_cnt_r;
  logic              err_r;
  logic              in_rdy_s;
  logic              req_val_s;
  logic              resp_rdy_s;
  logic              in_fire_s;
  logic              resp_fire_s;
  logic              wd_hit_s;
  logic              ser_done_s;

  // Next-state and handshake-ready decode
  always_comb begin
    state_nxt_s = state_r;
    in_rdy_s    = 1'b0;
    req_val_s   = 1'b0;
    resp_rdy_s  = 1'b0;
    case (state_r)
      COLLECT: begin
        in_rdy_s = 1'b1;
        if (in_val && (beat_r == BEAT_2)) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      ISSUE: begin
        req_val_s = 1'b1;
        if (muldivreq_rdy) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        resp_rdy_s = 1'b1;
        if (muldivresp_val) begin
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      EMIT: begin
        if (ser_done_s) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // Handshake events and watchdog threshold; a response on the limit cycle still flags
  always_comb begin
    in_fire_s   = in_rdy_s && in_val;
    resp_fire_s = resp_rdy_s && muldivresp_val;
    wd_hit_s    = TIMEOUT_EN && (state_r == WAIT) && ((wait_cnt_r + 16'd1) == TIMEOUT_LIMIT);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture indexed by input beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r    <= {WORD_W{1'b0}};
      b_r    <= {WORD_W{1'b0}};
      c_r    <= {WORD_W{1'b0}};
      beat_r <= BEAT_0;
    end else if (in_fire_s) begin
      case (beat_r)
        BEAT_0:  a_r <= in_msg;
        BEAT_1:  b_r <= in_msg;
        BEAT_2:  c_r <= in_msg;
        default: a_r <= a_r;
      endcase
      beat_r <= (beat_r == BEAT_2) ? BEAT_0 : (beat_r + 2'd1);
    end
  end

  // Watchdog counter (cleared while issuing) and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else begin
      if (state_r == ISSUE) begin
        wait_cnt_r <= 16'd0;
      end else if (state_r == WAIT) begin
        wait_cnt_r <= sat_inc16(wait_cnt_r);
      end
      if (wd_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end

  imuldiv_resp_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (resp_fire_s),
    .result  (muldivresp_msg_result),
    .out_msg (out_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .done    (ser_done_s)
  );

`ifdef IMULDIV_CLIENT_PERF_EN
  logic [31:0] txn_cnt_r;
  logic [15:0] lat_cnt_r;
  logic [15:0] last_lat_r;

  // Transaction count and request-to-response latency, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_cnt_r  <= 32'd0;
      lat_cnt_r  <= 16'd0;
      last_lat_r <= 16'd0;
    end else begin
      if (ser_done_s) begin
        txn_cnt_r <= txn_cnt_r + 32'd1;
      end
      if ((state_r == ISSUE) || (state_r == WAIT)) begin
        lat_cnt_r <= sat_inc16(lat_cnt_r);
      end else begin
        lat_cnt_r <= 16'd0;
      end
      if (resp_fire_s) begin
        last_lat_r <= sat_inc16(lat_cnt_r);
      end
    end
  end

  assign perf_txn_count    = txn_cnt_r;
  assign perf_last_latency = last_lat_r;
`else
  // Performance counters compiled out; no extra state.
`endif

  assign in_rdy           = in_rdy_s;
  assign muldivreq_val    = req_val_s;
  assign muldivresp_rdy   = resp_rdy_s;
  assign muldivreq_msg_fn = FN_CODE;
  assign muldivreq_msg_a  = a_r;
  assign muldivreq_msg_b  = b_r;
  assign muldivreq_msg_c  = c_r;
  assign err_timeout      = err_r;

endmodule

// File: tb/tb_imuldiv_three_mul_client.sv
// Directed bench for imuldiv_three_mul_client with an in-bench multiplier
// model; perf checks compile in with IMULDIV_CLIENT_PERF_EN.
module tb_imuldiv_three_mul_client;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_msg;
  logic        in_val;
  logic        in_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic [31:0] muldivreq_msg_c;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [95:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic [31:0] out_msg;
  logic        out_val;
  logic        out_rdy;
  logic        err_timeout;
`ifdef IMULDIV_CLIENT_PERF_EN
  logic [31:0] perf_txn_count;
  logic [15:0] perf_last_latency;
`endif

  int tests = 0;
  int fails = 0;

  imuldiv_three_mul_client #(.TIMEOUT_CYCLES(8), .FN_CODE(3'd0)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_msg                (in_msg),
    .in_val                (in_val),
    .in_rdy                (in_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_msg_c       (muldivreq_msg_c),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .out_msg               (out_msg),
    .out_val               (out_val),
    .out_rdy               (out_rdy),
    .err_timeout           (err_timeout)
`ifdef IMULDIV_CLIENT_PERF_EN
    ,
    .perf_txn_count        (perf_txn_count),
    .perf_last_latency     (perf_last_latency)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] prod96(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    logic signed [95:0] sa;
    logic signed [95:0] sb;
    logic signed [95:0] sc;
    sa = {{64{a[31]}}, a};
    sb = {{64{b[31]}}, b};
    sc = {{64{c[31]}}, c};
    return sa * sb * sc;
  endfunction

  // One full transaction; multiplier behaviour set by req_hold / resp_delay.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input int req_hold, input int resp_delay, input bit out_toggle,
                         input bit wd_check, output logic [95:0] got);
    logic [95:0] p;
    int k;
    int guard;
    p   = prod96(a, b, c);
    got = 96'd0;
    check("in_rdy_idle", {127'd0, in_rdy}, 128'd1);
    in_val = 1'b1;
    in_msg = a; step();
    in_msg = b; step();
    in_msg = c; step();
    in_val = 1'b0;
    in_msg = 32'd0;
    check("issue_first", {126'd0, muldivreq_val, in_rdy}, {126'd0, 2'b10});
    check("issue_ops", {32'd0, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c}, {32'd0, a, b, c});
    muldivreq_rdy = 1'b0;
    for (int i = 0; i < req_hold; i++) begin
      step();
      check("issue_hold", {31'd0, muldivreq_val, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c},
            {31'd0, 1'b1, a, b, c});
    end
    muldivreq_rdy = 1'b1;
    step();
    muldivreq_rdy = 1'b0;
    check("wait_enter", {125'd0, muldivresp_rdy, muldivreq_val, out_val}, {125'd0, 3'b100});
    for (int j = 1; j <= resp_delay; j++) begin
      step();
      if (wd_check && (j == 7)) check("wd_before", {127'd0, err_timeout}, 128'd0);
      if (wd_check && (j == 8)) check("wd_set", {127'd0, err_timeout}, 128'd1);
    end
    muldivresp_msg_result = p;
    muldivresp_val = 1'b1;
    step();
    muldivresp_val = 1'b0;
    muldivresp_msg_result = 96'd0;
    check("emit_enter", {126'd0, out_val, muldivresp_rdy}, {126'd0, 2'b10});
    k = 0;
    guard = 0;
    out_rdy = !out_toggle;
    while ((k < 3) && (guard < 40)) begin
      if (out_val && out_rdy) begin
        got[k*32 +: 32] = out_msg;
        check("emit_in_rdy", {127'd0, in_rdy}, 128'd0);
        k++;
      end
      step();
      guard++;
      if (out_toggle) out_rdy = !out_rdy;
    end
    out_rdy = 1'b0;
    check("emit_count", k, 3);
    check("back_idle", {126'd0, in_rdy, out_val}, {126'd0, 2'b10});
  endtask

  logic [95:0] got;

  initial begin
    reset = 1'b1;
    in_msg = 32'd0; in_val = 1'b0;
    muldivreq_rdy = 1'b0; muldivresp_val = 1'b0; muldivresp_msg_result = 96'd0;
    out_rdy = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_ctrl", {123'd0, in_rdy, muldivreq_val, muldivresp_rdy, out_val, err_timeout},
          {123'd0, 5'b10000});
    check("rst_ops", {32'd0, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c}, 128'd0);
    check("rst_out", {93'd0, muldivreq_msg_fn, out_msg}, 128'd0);
`ifdef IMULDIV_CLIENT_PERF_EN
    check("rst_perf", {80'd0, perf_txn_count, perf_last_latency}, 128'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: small mixed-sign product
    run_txn(32'd3, 32'hFFFFFFFE, 32'd5, 0, 0, 1'b0, 1'b0, got);
    check("t1_result", {32'd0, got}, {32'd0, 96'hFFFFFFFF_FFFFFFFF_FFFFFFE2});
    check("t1_err", {127'd0, err_timeout}, 128'd0);

    // 2: largest positive operands
    run_txn(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 1'b0, 1'b0, got);
    check("t2_result", {32'd0, got}, {32'd0, 96'h1FFFFFFF_40000001_7FFFFFFF});

    // 3: request backpressure and toggling downstream ready
    run_txn(32'h12345678, 32'h9ABCDEF0, 32'hFFFF0001, 10, 2, 1'b1, 1'b0, got);
    check("t3_result", {32'd0, got}, {32'd0, prod96(32'h12345678, 32'h9ABCDEF0, 32'hFFFF0001)});
    check("t3_err", {127'd0, err_timeout}, 128'd0);

    // 4: watchdog fires, late response still delivered
    run_txn(32'hFFFFFFFF, 32'h80000000, 32'h00000002, 0, 20, 1'b0, 1'b1, got);
    check("t4_result", {32'd0, got}, {32'd0, 96'h00000000_00000001_00000000});
    check("t4_sticky", {127'd0, err_timeout}, 128'd1);

    // 5: async reset mid-collection
    in_val = 1'b1;
    in_msg = 32'hAAAA5555; step();
    in_msg = 32'h5555AAAA; step();
    in_val = 1'b0;
    in_msg = 32'd0;
    check("t5_pre_a", {96'd0, muldivreq_msg_a}, {96'd0, 32'hAAAA5555});
    check("t5_pre_err", {127'd0, err_timeout}, 128'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_ctrl", {123'd0, in_rdy, muldivreq_val, muldivresp_rdy, out_val, err_timeout},
          {123'd0, 5'b10000});
    check("t5_rst_ops", {32'd0, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_txn(32'd2, 32'd3, 32'd4, 0, 1, 1'b0, 1'b0, got);
    check("t5_result", {32'd0, got}, 128'd24);
    check("t5_err", {127'd0, err_timeout}, 128'd0);

`ifdef IMULDIV_CLIENT_PERF_EN
    // 6: perf counters over three transactions with a 7-cycle multiplier
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_txn(32'd7 + 32'(t), 32'hFFFFFFF0, 32'd9, 0, 6, 1'b0, 1'b0, got);
      check("t6_result", {32'd0, got}, {32'd0, prod96(32'd7 + 32'(t), 32'hFFFFFFF0, 32'd9)});
      check("t6_latency", {112'd0, perf_last_latency}, 128'd8);
    end
    check("t6_txn_count", {96'd0, perf_txn_count}, 128'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
